boot_image_loader: RTL and testbench
====================================

# boot_image_loader

Loads a program image into main memory before the cores run, then releases them. It sits upstream of `main_memory`, in front of its single port, while the top level muxes the port between this block and `main_memory_interface` using `mem_owner`. It accepts a word stream from a host link on a valid/ready handshake, with the per-core entry addresses in a header. It writes each image word to memory, then pulses `start` and drives `program_address` for every core.

## Interface
- `NUM_CORES`, 2, cores released; header length in words
- `DATA_WIDTH`, 32, word width
- `ADDRESS_BITS`, 32, address width
- `MSG_BITS`, 4, main-memory message width
- `LOAD_BASE`, 0, byte address of first image word
- `MAX_WORDS`, 1024, image capacity in words (matches main_memory INDEX_BITS=10)
- `clock`  in  1  single clock
- `reset`  in  1  asynchronous, active-high
- `host_valid`  in  1  host word valid
- `host_ready`  out  1  loader accepts word this cycle
- `host_data`  in  DATA_WIDTH  header entry PC or image word
- `host_last`  in  1  final word of stream
- `mem_msg_out`  out  MSG_BITS  request to main_memory
- `mem_address_out`  out  ADDRESS_BITS  byte address
- `mem_data_out`  out  DATA_WIDTH  write data
- `mem_msg_in`  in  MSG_BITS  main_memory response
- `mem_owner`  out  1  1 = loader owns memory port
- `start`  out  1  one-cycle release pulse to all cores
- `program_address`  out  NUM_CORES*ADDRESS_BITS  entry PC, core i at slice i
- `done`  out  1  image loaded, cores released
- `error`  out  1  malformed or oversized stream

## Operation
- States: HEADER, LOAD, WRITE, START, RUN, ERROR. Reset enters HEADER.
- **HEADER**
  - `host_ready`=1. Each accepted word goes to entry register `hdr_cnt`, which increments.
  - After NUM_CORES words → LOAD.
  - `host_last` on any header word → ERROR.
- **LOAD**
  - `host_ready`=1. On accept, latch the word into `data_q` and the last flag into `last_q` → WRITE.
- **WRITE**
  - Drive `mem_msg_out`=WB_REQ, `mem_address_out`=LOAD_BASE+4*`word_cnt`, `mem_data_out`=`data_q`. Hold all three until `mem_msg_in`==MEM_READY.
  - On MEM_READY, `word_cnt`++. Then go to START if `last_q`, else LOAD.
- **START**
  - `start`=1 for exactly one cycle, `mem_owner` still 1. Next cycle → RUN.
- **RUN**
  - `mem_owner`=0, `done`=1, `mem_msg_out`=NO_REQ, `host_ready`=0.
  - Terminal until reset. Further host words are ignored, never accepted.
- **ERROR**
  - `error`=1, `host_ready`=0, `mem_owner`=1 (cores stay isolated), no `start`. Terminal until reset.
- **Overflow:** accepting a word in LOAD when `word_cnt`==MAX_WORDS → ERROR. The word is not written.
- `program_address` slices are held from the end of HEADER onward. They read 0 before their header word arrives.
- `word_cnt` width is clog2(MAX_WORDS)+1 and does not wrap.

## Timing
- **Reset values:** `host_ready`=0 during reset and 1 the first cycle after; `mem_msg_out`=NO_REQ, `mem_address_out`=0, `mem_data_out`=0, `mem_owner`=1, `start`=0, `done`=0, `error`=0, `program_address`=0.
- **Host handshake:** a transfer happens on a rising edge with `host_valid`&&`host_ready`. `host_ready` is a registered function of state only, not combinational on `host_valid`.
- **Memory handshake:**
  - WB_REQ appears the cycle after acceptance.
  - The next host word can be accepted the cycle after MEM_READY.
  - Minimum of 3 cycles per image word with a zero-wait memory.
- MEM_READY observed in a state other than WRITE is ignored.
- `start` rises the cycle after the last MEM_READY.
- **Reset mid-operation:**
  - All outputs return to reset values immediately (asynchronous).
  - A partially written image is not cleared.
  - The sequence restarts in HEADER.

## Structure
- Shared package: MSG encodings (NO_REQ, WB_REQ, MEM_READY), shared with main_memory and main_memory_interface; the state enum.
- One sub-module is natural: `boot_header_regs`, which captures the NUM_CORES entry PCs and flattens them onto `program_address`.
- The port mux sits at the top level, not inside this block.

## Test plan
- **Normal load:** NUM_CORES=2, header 0x000, 0x040, image 0x00000013, 0x00100093, 0x00200113 (last) with a 1-cycle memory.
  - Required: three WB_REQ writes to 0x0, 0x4, 0x8 with matching data.
  - Then a single-cycle `start`, `program_address`={0x040,0x000}, then `done`=1 and `mem_owner`=0.
- **Back-pressure:** memory delays MEM_READY by 5 cycles.
  - Required: request and address/data stable for 6 cycles, `host_ready`=0 throughout.
- **Short header:** `host_last` on the first header word → `error`=1, no `start`, no WB_REQ ever issued.
- **Overflow:** MAX_WORDS=4, stream of 5 image words.
  - Required: 4 writes, 5th accepted → ERROR, no `start`.
- **Reset mid-WRITE:** assert reset while WB_REQ is pending.
  - Required: outputs reset the same cycle.
  - A fresh stream loads from LOAD_BASE again.
- **Post-RUN traffic:** `host_valid` held high in RUN → `host_ready` stays 0 and `mem_msg_out` stays NO_REQ.

Source files
------------

// File: rtl/boot_image_loader_pkg.sv
// Message encodings shared with main_memory / main_memory_interface, and the loader state set.
package boot_image_loader_pkg;

   localparam logic [3:0] NO_REQ    = 4'd0;
   localparam logic [3:0] WB_REQ    = 4'd2;
   localparam logic [3:0] MEM_READY = 4'd4;

   typedef enum logic [2:0] {
      HEADER,
      LOAD,
      WRITE,
      START,
      RUN,
      ERROR
   } loader_state_e;

endpackage

// File: rtl/boot_image_loader_header_regs.sv
// Captures one entry PC per core from the stream header and flattens them onto program_address.
module boot_header_regs #(
   parameter int NUM_CORES    = 2,
   parameter int DATA_WIDTH   = 32,
   parameter int ADDRESS_BITS = 32
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              capture,
   input  logic [DATA_WIDTH-1:0]             entry,
   output logic                              last_entry,
   output logic [NUM_CORES*ADDRESS_BITS-1:0] program_address
);

   localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   logic [IDX_W-1:0]        hdr_cnt;
   logic [ADDRESS_BITS-1:0] entry_q [NUM_CORES];

   assign last_entry = (hdr_cnt == IDX_W'(NUM_CORES - 1));

   // The counter parks on the final slot; capture is never raised again once the header is complete.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hdr_cnt <= '0;
         for (int i = 0; i < NUM_CORES; i++) begin
            entry_q[i] <= '0;
         end
      end else if (capture) begin
         entry_q[hdr_cnt] <= ADDRESS_BITS'(entry);
         if (!last_entry) begin
            hdr_cnt <= hdr_cnt + 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_CORES; g++) begin : g_flat
      assign program_address[g*ADDRESS_BITS +: ADDRESS_BITS] = entry_q[g];
   end

endmodule

// File: rtl/boot_image_loader.sv
// Streams a boot image from the host link into main memory, then releases all cores at their entry PCs.
module boot_image_loader
   import boot_image_loader_pkg::*;
#(
   parameter int                    NUM_CORES    = 2,
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    ADDRESS_BITS = 32,
   parameter int                    MSG_BITS     = 4,
   parameter logic [ADDRESS_BITS-1:0] LOAD_BASE  = '0,
   parameter int                    MAX_WORDS    = 1024
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              host_valid,
   output logic                              host_ready,
   input  logic [DATA_WIDTH-1:0]             host_data,
   input  logic                              host_last,
   output logic [MSG_BITS-1:0]               mem_msg_out,
   output logic [ADDRESS_BITS-1:0]           mem_address_out,
   output logic [DATA_WIDTH-1:0]             mem_data_out,
   input  logic [MSG_BITS-1:0]               mem_msg_in,
   output logic                              mem_owner,
   output logic                              start,
   output logic [NUM_CORES*ADDRESS_BITS-1:0] program_address,
   output logic                              done,
   output logic                              error
);

   localparam int WCNT_W = $clog2(MAX_WORDS) + 1;

   loader_state_e           state, next_state;
   logic [WCNT_W-1:0]       word_cnt;
   logic [DATA_WIDTH-1:0]   data_q;
   logic                    last_q;
   logic                    accept;
   logic                    mem_done;
   logic                    hdr_capture;
   logic                    last_entry;

   assign accept   = host_valid && host_ready;
   assign mem_done = (state == WRITE) && (mem_msg_in == MSG_BITS'(MEM_READY));

   boot_header_regs #(
      .NUM_CORES    (NUM_CORES),
      .DATA_WIDTH   (DATA_WIDTH),
      .ADDRESS_BITS (ADDRESS_BITS)
   ) u_header_regs (
      .clock           (clock),
      .reset           (reset),
      .capture         (hdr_capture),
      .entry           (host_data),
      .last_entry      (last_entry),
      .program_address (program_address)
   );

   // host_ready is registered from the next state so it never depends on host_valid.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= HEADER;
         host_ready <= 1'b0;
         word_cnt   <= '0;
      end else begin
         state      <= next_state;
         host_ready <= (next_state == HEADER) || (next_state == LOAD);
         if (mem_done) begin
            word_cnt <= word_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (accept && state == LOAD) begin
         data_q <= host_data;
         last_q <= host_last;
      end
   end

   always_comb begin
      next_state      = state;
      hdr_capture     = 1'b0;
      mem_msg_out     = MSG_BITS'(NO_REQ);
      mem_address_out = '0;
      mem_data_out    = '0;
      mem_owner       = 1'b1;
      start           = 1'b0;
      done            = 1'b0;
      error           = 1'b0;
      case (state)
         HEADER: begin
            if (accept) begin
               hdr_capture = 1'b1;
               if (host_last) begin
                  next_state = ERROR;
               end else if (last_entry) begin
                  next_state = LOAD;
               end
            end
         end
         LOAD: begin
            // A word arriving with the image already full is dropped and the load aborts.
            if (accept) begin
               if (word_cnt == WCNT_W'(MAX_WORDS)) begin
                  next_state = ERROR;
               end else begin
                  next_state = WRITE;
               end
            end
         end
         WRITE: begin
            mem_msg_out     = MSG_BITS'(WB_REQ);
            mem_address_out = LOAD_BASE + ADDRESS_BITS'({word_cnt, 2'b00});
            mem_data_out    = data_q;
            if (mem_done) begin
               next_state = last_q ? START : LOAD;
            end
         end
         START: begin
            start      = 1'b1;
            next_state = RUN;
         end
         RUN: begin
            mem_owner = 1'b0;
            done      = 1'b1;
         end
         ERROR: begin
            error = 1'b1;
         end
         default: begin
            next_state = HEADER;
         end
      endcase
   end

endmodule

// File: tb/tb_boot_image_loader.sv
// Bench for boot_image_loader: image vector table, write scoreboard and multi-cycle corner sequences.
module tb_boot_image_loader;
   import boot_image_loader_pkg::*;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic [31:0] exp_addr;
   } vec_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        host_valid = 1'b0;
   logic        host_ready;
   logic [31:0] host_data = '0;
   logic        host_last = 1'b0;
   logic [3:0]  mem_msg_out;
   logic [31:0] mem_address_out;
   logic [31:0] mem_data_out;
   logic [3:0]  mem_msg_in;
   logic        mem_owner;
   logic        start;
   logic [63:0] program_address;
   logic        done;
   logic        error;

   int checks = 0;
   int errors = 0;
   int mem_delay = 1;
   int wait_cnt;
   int cyc = 0;
   int start_cnt = 0;
   int wb_cycles = 0;
   int last_rdy_cyc = 0;
   int start_cyc = 0;
   wr_t exp_q[$];
   wr_t got_q[$];

   boot_image_loader #(
      .NUM_CORES    (2),
      .DATA_WIDTH   (32),
      .ADDRESS_BITS (32),
      .MSG_BITS     (4),
      .LOAD_BASE    (32'h0),
      .MAX_WORDS    (4)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .host_valid      (host_valid),
      .host_ready      (host_ready),
      .host_data       (host_data),
      .host_last       (host_last),
      .mem_msg_out     (mem_msg_out),
      .mem_address_out (mem_address_out),
      .mem_data_out    (mem_data_out),
      .mem_msg_in      (mem_msg_in),
      .mem_owner       (mem_owner),
      .start           (start),
      .program_address (program_address),
      .done            (done),
      .error           (error)
   );

   always #5 clock = ~clock;

   // Memory model: answers MEM_READY for one cycle after mem_delay cycles of WB_REQ.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_msg_in <= NO_REQ;
         wait_cnt   <= 0;
      end else if (mem_msg_out == WB_REQ && mem_msg_in != MEM_READY) begin
         if (wait_cnt == mem_delay - 1) begin
            mem_msg_in <= MEM_READY;
            wait_cnt   <= 0;
         end else begin
            wait_cnt <= wait_cnt + 1;
         end
      end else begin
         mem_msg_in <= NO_REQ;
      end
   end

   // Monitor: records committed writes and start pulses, sampled on the falling edge.
   always @(negedge clock) begin
      if (reset) begin
         start_cnt = 0;
         wb_cycles = 0;
         got_q.delete();
      end else begin
         cyc++;
         if (mem_msg_out == WB_REQ) begin
            wb_cycles++;
            if (mem_msg_in == MEM_READY) begin
               got_q.push_back('{addr: mem_address_out, data: mem_data_out});
               last_rdy_cyc = cyc;
            end
         end
         if (start) begin
            start_cnt++;
            start_cyc = cyc;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the transfer.
   task automatic send(input logic [31:0] data, input logic last);
      bit ok = 0;
      host_valid = 1'b1;
      host_data  = data;
      host_last  = last;
      for (int t = 0; t < 200; t++) begin
         if (host_ready) begin
            ok = 1;
            @(negedge clock);
            break;
         end
         @(negedge clock);
      end
      host_valid = 1'b0;
      host_last  = 1'b0;
      if (!ok) check("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic do_reset();
      @(negedge clock);
      #2 reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      #2 reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic wait_done(input string name);
      bit ok = 0;
      for (int t = 0; t < 200; t++) begin
         if (done) begin
            ok = 1;
            break;
         end
         @(negedge clock);
      end
      check(name, {63'd0, ok}, 64'd1);
   endtask

   task automatic compare_writes(input string name);
      check({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         wr_t e, g;
         e = exp_q.pop_front();
         g = got_q.pop_front();
         check({name, "_addr"}, {32'd0, g.addr}, {32'd0, e.addr});
         check({name, "_data"}, {32'd0, g.data}, {32'd0, e.data});
      end
      exp_q.delete();
   endtask

   initial begin
      vec_t norm_vec[3];
      int   stable_cyc;
      bit   stable_ok;
      norm_vec[0] = '{data: 32'h0000_0013, last: 1'b0, exp_addr: 32'h0};
      norm_vec[1] = '{data: 32'h0010_0093, last: 1'b0, exp_addr: 32'h4};
      norm_vec[2] = '{data: 32'h0020_0113, last: 1'b1, exp_addr: 32'h8};

      // Reset values
      @(negedge clock);
      #1;
      check("rst_host_ready", {63'd0, host_ready}, 64'd0);
      check("rst_msg", {60'd0, mem_msg_out}, {60'd0, NO_REQ});
      check("rst_addr", {32'd0, mem_address_out}, 64'd0);
      check("rst_data", {32'd0, mem_data_out}, 64'd0);
      check("rst_owner", {63'd0, mem_owner}, 64'd1);
      check("rst_flags", {61'd0, start, done, error}, 64'd0);
      check("rst_pa", program_address, 64'd0);
      #1 reset = 1'b0;
      @(negedge clock);
      check("ready_after_rst", {63'd0, host_ready}, 64'd1);

      // Normal load with a 1-cycle memory
      mem_delay = 1;
      send(32'h000, 1'b0);
      check("pa_partial", program_address, 64'd0);
      send(32'h040, 1'b0);
      check("pa_header", program_address, 64'h0000_0040_0000_0000);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back('{addr: norm_vec[i].exp_addr, data: norm_vec[i].data});
         send(norm_vec[i].data, norm_vec[i].last);
      end
      wait_done("normal_done");
      @(negedge clock);
      compare_writes("normal_wr");
      check("normal_start_once", 64'(start_cnt), 64'd1);
      check("normal_start_timing", 64'(start_cyc), 64'(last_rdy_cyc + 1));
      check("normal_pa", program_address, 64'h0000_0040_0000_0000);
      check("normal_owner", {63'd0, mem_owner}, 64'd0);
      check("normal_error", {63'd0, error}, 64'd0);

      // Host traffic after release is never accepted
      host_valid = 1'b1;
      host_data  = 32'hDEAD_BEEF;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         check("run_ready", {63'd0, host_ready}, 64'd0);
         check("run_msg", {60'd0, mem_msg_out}, {60'd0, NO_REQ});
      end
      host_valid = 1'b0;
      check("run_no_writes", 64'(got_q.size()), 64'd0);
      check("run_done", {63'd0, done}, 64'd1);

      // Back-pressure: MEM_READY five cycles late
      do_reset();
      mem_delay = 5;
      send(32'h100, 1'b0);
      send(32'h200, 1'b0);
      exp_q.push_back('{addr: 32'h0, data: 32'hCAFE_0001});
      send(32'hCAFE_0001, 1'b1);
      stable_cyc = 0;
      stable_ok  = 1;
      for (int t = 0; t < 20 && mem_msg_out == WB_REQ; t++) begin
         stable_cyc++;
         if (mem_address_out != 32'h0 || mem_data_out != 32'hCAFE_0001 || host_ready)
            stable_ok = 0;
         @(negedge clock);
      end
      check("bp_req_cycles", 64'(stable_cyc), 64'd6);
      check("bp_stable", {63'd0, stable_ok}, 64'd1);
      wait_done("bp_done");
      @(negedge clock);
      compare_writes("bp_wr");
      check("bp_pa", program_address, 64'h0000_0200_0000_0100);

      // Short header: last flag on the first header word
      do_reset();
      mem_delay = 1;
      send(32'h000, 1'b1);
      check("short_error", {63'd0, error}, 64'd1);
      repeat (5) @(negedge clock);
      check("short_no_wb", 64'(wb_cycles), 64'd0);
      check("short_no_start", 64'(start_cnt), 64'd0);
      check("short_ready", {63'd0, host_ready}, 64'd0);
      check("short_owner", {63'd0, mem_owner}, 64'd1);

      // Overflow: five image words into a four-word image
      do_reset();
      send(32'h10, 1'b0);
      send(32'h20, 1'b0);
      for (int i = 0; i < 5; i++) begin
         if (i < 4) exp_q.push_back('{addr: 32'(i * 4), data: 32'hA000_0000 + 32'(i)});
         send(32'hA000_0000 + 32'(i), 1'b0);
      end
      check("ovf_error", {63'd0, error}, 64'd1);
      repeat (5) @(negedge clock);
      compare_writes("ovf_wr");
      check("ovf_no_start", 64'(start_cnt), 64'd0);
      check("ovf_owner", {63'd0, mem_owner}, 64'd1);

      // Reset while a write is pending
      do_reset();
      mem_delay = 5;
      send(32'h0, 1'b0);
      send(32'h0, 1'b0);
      send(32'h5555_AAAA, 1'b0);
      @(negedge clock);
      check("mid_req_pending", {60'd0, mem_msg_out}, {60'd0, WB_REQ});
      #2 reset = 1'b1;
      #1;
      check("mid_rst_msg", {60'd0, mem_msg_out}, {60'd0, NO_REQ});
      check("mid_rst_addr_data", {mem_address_out, mem_data_out}, 64'd0);
      check("mid_rst_ready", {63'd0, host_ready}, 64'd0);
      check("mid_rst_owner", {63'd0, mem_owner}, 64'd1);
      @(negedge clock);
      #2 reset = 1'b0;
      @(negedge clock);
      mem_delay = 1;
      send(32'h300, 1'b0);
      send(32'h400, 1'b0);
      exp_q.push_back('{addr: 32'h0, data: 32'h1234_5678});
      send(32'h1234_5678, 1'b1);
      wait_done("mid_done");
      @(negedge clock);
      compare_writes("mid_wr");
      check("mid_pa", program_address, 64'h0000_0400_0000_0300);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
